score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/ddr_definitions.sv | 15 +
 rtl/bcd_add_sat.sv | 35 +++
 rtl/score_keeper.sv | 127 ++++++++++++
 tb/tb_score_keeper.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr_definitions.sv
// Shared encodings and constants for the score keeper.
// The multiplier tiers take effect when SCORE_COMBO_MULTIPLIER_EN is defined.
package ddr_definitions;

    typedef enum logic [1:0] {
        SK_IDLE = 2'd0,
        SK_PLAY = 2'd1,
        SK_OVER = 2'd2
    } sk_state_e;

    localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;
    localparam int unsigned MAX_MULT      = 4;
    localparam logic [7:0]  COMBO_MAX     = 8'd255;

endpackage

// File: rtl/bcd_add_sat.sv
// Combinational four-digit packed-BCD adder for a small binary addend.
// A carry out of the thousands digit clamps the result to 9999.
module bcd_add_sat
    import ddr_definitions::*;
(
    input  logic [15:0] val_i,
    input  logic [2:0]  addend_i,
    output logic [15:0] sum_o
);

    logic [15:0] raw;
    logic [4:0]  carry;
    logic [4:0]  dsum;
    logic [4:0]  dadj;

    always_comb begin
        raw   = '0;
        carry = {2'b00, addend_i};
        dsum  = '0;
        dadj  = '0;
        for (int i = 0; i < 4; i++) begin
            dsum = {1'b0, val_i[4*i +: 4]} + carry;
            dadj = dsum - 5'd10;
            if (dsum > 5'd9) begin
                raw[4*i +: 4] = dadj[3:0];
                carry         = 5'd1;
            end else begin
                raw[4*i +: 4] = dsum[3:0];
                carry         = 5'd0;
            end
        end
        sum_o = (carry != 5'd0) ? SCORE_MAX_BCD : raw;
    end

endmodule

// File: rtl/score_keeper.sv
// Rhythm-game score keeper: edge-detects hit levels, tracks BCD score, combo and health.
// Optional combo multiplier is enabled by defining SCORE_COMBO_MULTIPLIER_EN.
module score_keeper
    import ddr_definitions::*;
#(
    parameter int MAX_HEALTH = 8,
    parameter int COMBO_STEP = 10
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        correctHit,
    input  logic        incorrectHit,
    output logic [15:0] score_bcd,
    output logic [7:0]  combo,
    output logic [7:0]  max_combo,
    output logic [3:0]  health,
    output logic        game_over,
    output logic        playing
);

`ifdef SCORE_COMBO_MULTIPLIER_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif

    localparam logic [3:0] HEALTH_INIT = 4'(MAX_HEALTH);
    localparam logic [7:0] STEP        = 8'(COMBO_STEP);

    sk_state_e   state_q;
    logic [15:0] score_q;
    logic [7:0]  combo_q;
    logic [7:0]  max_q;
    logic [3:0]  health_q;
    logic        over_q;
    logic        play_q;
    logic        corr_q;
    logic        inc_q;

    logic        corr_rise;
    logic        inc_rise;
    logic [7:0]  tier;
    logic [2:0]  points;
    logic [15:0] score_d;
    logic [7:0]  combo_d;

    assign corr_rise = correctHit & ~corr_q;
    assign inc_rise  = incorrectHit & ~inc_q;

    // Tier uses the combo before this hit is counted.
    assign tier   = combo_q / STEP;
    assign points = !MULT_EN            ? 3'd1 :
                    (tier >= 8'd3)      ? 3'(MAX_MULT) :
                                          3'(tier + 8'd1);

    assign combo_d = (combo_q == COMBO_MAX) ? combo_q : combo_q + 8'd1;

    bcd_add_sat u_bcd_add_sat (
        .val_i    (score_q),
        .addend_i (points),
        .sum_o    (score_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SK_IDLE;
            score_q  <= '0;
            combo_q  <= '0;
            max_q    <= '0;
            health_q <= HEALTH_INIT;
            over_q   <= 1'b0;
            play_q   <= 1'b0;
            corr_q   <= 1'b0;
            inc_q    <= 1'b0;
        end else begin
            corr_q <= correctHit;
            inc_q  <= incorrectHit;
            case (state_q)
                SK_IDLE, SK_OVER: begin
                    if (start) begin
                        state_q  <= SK_PLAY;
                        score_q  <= '0;
                        combo_q  <= '0;
                        max_q    <= '0;
                        health_q <= HEALTH_INIT;
                        over_q   <= 1'b0;
                        play_q   <= 1'b1;
                    end
                end
                SK_PLAY: begin
                    // A miss wins over a simultaneous correct hit.
                    if (inc_rise) begin
                        combo_q <= '0;
                        if (health_q <= 4'd1) begin
                            health_q <= '0;
                            state_q  <= SK_OVER;
                            over_q   <= 1'b1;
                            play_q   <= 1'b0;
                        end else begin
                            health_q <= health_q - 4'd1;
                        end
                    end else if (corr_rise) begin
                        score_q <= score_d;
                        combo_q <= combo_d;
                        if (combo_d > max_q) begin
                            max_q <= combo_d;
                        end
                    end
                end
                default: begin
                    state_q <= SK_IDLE;
                    play_q  <= 1'b0;
                    over_q  <= 1'b0;
                end
            endcase
        end
    end

    assign score_bcd = score_q;
    assign combo     = combo_q;
    assign max_combo = max_q;
    assign health    = health_q;
    assign game_over = over_q;
    assign playing   = play_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a per-cycle vector table plus multi-cycle sequences.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        correctHit;
    logic        incorrectHit;
    logic [15:0] score_bcd;
    logic [7:0]  combo;
    logic [7:0]  max_combo;
    logic [3:0]  health;
    logic        game_over;
    logic        playing;

    always #5 clk = ~clk;

    score_keeper #(.MAX_HEALTH(8), .COMBO_STEP(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .correctHit   (correctHit),
        .incorrectHit (incorrectHit),
        .score_bcd    (score_bcd),
        .combo        (combo),
        .max_combo    (max_combo),
        .health       (health),
        .game_over    (game_over),
        .playing      (playing)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic        cor;
        logic        inc;
        logic [15:0] score;
        logic [7:0]  combo;
        logic [7:0]  mx;
        logic [3:0]  health;
        logic        go;
        logic        play;
    } vec_t;

    vec_t vecs [24];

    int n_tests = 0;
    int n_fail  = 0;

    int m_score;
    int m_combo;
    int m_max;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return {26'd0, score_bcd, combo, max_combo, health, game_over, playing};
    endfunction

    function automatic logic [63:0] expv(input logic [15:0] s, input logic [7:0] c,
                                         input logic [7:0] m, input logic [3:0] h,
                                         input logic go, input logic pl);
        return {26'd0, s, c, m, h, go, pl};
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic restart();
        rst = 1'b1; start = 1'b0; correctHit = 1'b0; incorrectHit = 1'b0;
        tick();
        rst = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        m_score = 0; m_combo = 0; m_max = 0;
    endtask

    task automatic hit();
        int pts;
        correctHit = 1'b1;
        tick();
        correctHit = 1'b0;
`ifdef SCORE_COMBO_MULTIPLIER_EN
        pts = 1 + (((m_combo / 10) > 3) ? 3 : (m_combo / 10));
`else
        pts = 1;
`endif
        m_score = (m_score + pts > 9999) ? 9999 : m_score + pts;
        m_combo = (m_combo == 255) ? 255 : m_combo + 1;
        if (m_combo > m_max) m_max = m_combo;
        tick();
    endtask

    initial begin
        //         rst   st    cor   inc   score     cmb mx  hp    go    play
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, 4'd8, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 0, 4'd8, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, 4'd8, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 0, 4'd8, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1, 1, 4'd8, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1, 1, 4'd8, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1, 1, 4'd8, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 2, 2, 4'd8, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 2, 2, 4'd8, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 0, 2, 4'd7, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 0, 2, 4'd7, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 0, 2, 4'd7, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 1, 2, 4'd7, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0003, 1, 2, 4'd7, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0003, 1, 2, 4'd7, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0004, 2, 2, 4'd7, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 2, 2, 4'd7, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0004, 0, 2, 4'd6, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 0, 2, 4'd6, 1'b0, 1'b1};
        vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 0, 4'd8, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 0, 0, 4'd8, 1'b0, 1'b1};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 0, 4'd8, 1'b0, 1'b1};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, 4'd8, 1'b0, 1'b1};
        vecs[23] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1, 1, 4'd8, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; correctHit = 1'b0; incorrectHit = 1'b0;

        for (int i = 0; i < 24; i++) begin
            rst          = vecs[i].rst;
            start        = vecs[i].start;
            correctHit   = vecs[i].cor;
            incorrectHit = vecs[i].inc;
            tick();
            check($sformatf("vec%0d", i), outs(),
                  expv(vecs[i].score, vecs[i].combo, vecs[i].mx, vecs[i].health,
                       vecs[i].go, vecs[i].play));
        end

        // Twelve correct hits from a fresh game.
        restart();
        for (int i = 0; i < 12; i++) hit();
`ifdef SCORE_COMBO_MULTIPLIER_EN
        check("twelve_hits", outs(), expv(16'h0014, 8'd12, 8'd12, 4'd8, 1'b0, 1'b1));
`else
        check("twelve_hits", outs(), expv(16'h0012, 8'd12, 8'd12, 4'd8, 1'b0, 1'b1));
`endif

        // A level held for 50 cycles counts once.
        restart();
        correctHit = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        correctHit = 1'b0;
        tick();
        check("held_level", outs(), expv(16'h0001, 8'd1, 8'd1, 4'd8, 1'b0, 1'b1));

        // Simultaneous hit at combo 5, then reset mid-game.
        restart();
        for (int i = 0; i < 5; i++) hit();
        correctHit = 1'b1; incorrectHit = 1'b1;
        tick();
        check("simultaneous", outs(), expv(16'h0005, 8'd0, 8'd5, 4'd7, 1'b0, 1'b1));
        rst = 1'b1;
        correctHit = 1'b0; incorrectHit = 1'b0;
        tick();
        correctHit = 1'b1;
        tick();
        check("rst_midgame", outs(), expv(16'h0000, 8'd0, 8'd0, 4'd8, 1'b0, 1'b0));
        rst = 1'b0; correctHit = 1'b0;
        tick();

        // Health runs out; final score stays visible in OVER; start resumes.
        restart();
        for (int i = 0; i < 3; i++) hit();
        for (int i = 1; i <= 8; i++) begin
            incorrectHit = 1'b1;
            tick();
            check($sformatf("miss%0d", i), outs(),
                  expv(16'h0003, 8'd0, 8'd3, 4'(8 - i), 1'b0 + (i == 8), 1'b0 + (i != 8)));
            incorrectHit = 1'b0;
            tick();
        end
        correctHit = 1'b1;
        tick();
        correctHit = 1'b0; incorrectHit = 1'b1;
        tick();
        incorrectHit = 1'b0;
        tick();
        check("over_hold", outs(), expv(16'h0003, 8'd0, 8'd3, 4'd0, 1'b1, 1'b0));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("over_restart", outs(), expv(16'h0000, 8'd0, 8'd0, 4'd8, 1'b0, 1'b1));

        // Drive the score up to saturation; combo also saturates.
        restart();
        for (int k = 0; k < 12000 && m_score < 9998; k++) hit();
        check("near_max", outs(), expv(to_bcd(m_score), 8'(m_combo), 8'(m_max), 4'd8, 1'b0, 1'b1));
        hit();
        hit();
        check("score_sat", outs(), expv(16'h9999, 8'd255, 8'd255, 4'd8, 1'b0, 1'b1));
        hit();
        check("score_sat_hold", outs(), expv(16'h9999, 8'd255, 8'd255, 4'd8, 1'b0, 1'b1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
